apb_slave_if: RTL and testbench

APB_SLAVE_IF -- requirements
Module: apb_slave_if

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_timeout_cnt.sv | 42 ++++
 rtl/apb_slave_if.sv | 146 ++++++++++++++
 tb/tb_apb_slave_if.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_pkg : shared FSM state type and transfer-error causes, rev 1.0
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    localparam logic [1:0] c_cause_none    = 2'd0;
    localparam logic [1:0] c_cause_addr    = 2'd1;
    localparam logic [1:0] c_cause_timeout = 2'd2;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_timeout_cnt : backend-ack wait counter with expire flag, rev 1.0
// ---------------------------------------------------------------------------
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires on the increment that would make the count reach TIMEOUT-1.
    assign expire = enable & ~clear & (cnt_q == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_slave_if : APB slave front-end to a word-register backend, rev 1.0
// ---------------------------------------------------------------------------
module apb_slave_if
    import apb_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [19:0] BASE_ADDR_HI = 20'h4000_1,
    parameter int          REG_DEPTH    = 64,
    parameter int          TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] reg_addr_offset,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack
);

    localparam logic [ADDR_WIDTH:0] c_offset_limit = (ADDR_WIDTH + 1)'(REG_DEPTH * 4);

    apb_state_e            state_q, state_d;
    logic                  err_q, err_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_start;
    logic                  w_addr_err;
    logic                  w_cnt_clear;
    logic                  w_cnt_en;
    logic                  w_cnt_expire;
    logic [1:0]            w_cause;

    assign w_offset   = paddr[ADDR_WIDTH-1:0];
    assign w_start    = psel & penable & (state_q == ST_IDLE);
    assign w_addr_err = (paddr[31:12] != BASE_ADDR_HI) | (paddr[1:0] != 2'b00) |
                        ({1'b0, w_offset} >= c_offset_limit);

    // Strobes are combinational; gating with rst_n keeps them quiet during reset.
    assign reg_wr_en = rst_n & w_start & ~w_addr_err & pwrite;
    assign reg_rd_en = rst_n & w_start & ~w_addr_err & ~pwrite;

    assign reg_addr_offset = (state_q == ST_IDLE) ? w_offset : offset_q;
    assign reg_wdata       = (state_q == ST_IDLE) ? pwdata   : wdata_q;

    assign pready  = (state_q == ST_RESP);
    assign pslverr = pready & err_q;
    assign prdata  = prdata_q;

    assign w_cnt_clear = (state_q != ST_WAIT);
    assign w_cnt_en    = (state_q == ST_WAIT) & psel & ~reg_ack;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .expire (w_cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        write_d  = write_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        prdata_d = '0;
        w_cause  = c_cause_none;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_addr_err) begin
                        w_cause = c_cause_addr;
                        state_d = ST_RESP;
                    end else begin
                        offset_d = w_offset;
                        wdata_d  = pwdata;
                        write_d  = pwrite;
                        if (reg_ack) begin
                            state_d = ST_RESP;
                            if (!pwrite) prdata_d = reg_rdata;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (reg_ack) begin
                    state_d = ST_RESP;
                    if (!write_q) prdata_d = reg_rdata;
                end else if (w_cnt_expire) begin
                    w_cause = c_cause_timeout;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            err_d = (w_cause != c_cause_none);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            offset_q <= '0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            write_q  <= write_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_slave_if : directed vector bench for apb_slave_if, rev 1.0
// ---------------------------------------------------------------------------
module tb_apb_slave_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [11:0] reg_addr_offset;
    logic        reg_wr_en, reg_rd_en;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_slave_if #(
        .ADDR_WIDTH   (12),
        .DATA_WIDTH   (32),
        .BASE_ADDR_HI (20'h4000_1),
        .REG_DEPTH    (64),
        .TIMEOUT      (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .reg_addr_offset (reg_addr_offset),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_en       (reg_rd_en),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_ack         (reg_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          ack_dly;     // cycles after access start; -1 = never
        logic [31:0] rdata;
        int          exp_lat;     // cycle of pready relative to access start
        logic        exp_err;
        logic [31:0] exp_prdata;
        logic        exp_strobe;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int          lat;
        int          nstb;
        logic        err;
        logic [31:0] rd;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
        pwdata = v.wdata; reg_ack = 1'b0; reg_rdata = v.rdata;
        #1 chk("setup_no_strobe", 32'(reg_wr_en | reg_rd_en), 32'd0);
        @(negedge clk);
        penable = 1'b1;
        reg_ack = (v.ack_dly == 0);
        #1;
        chk("wr_en", 32'(reg_wr_en), 32'(v.exp_strobe & v.wr));
        chk("rd_en", 32'(reg_rd_en), 32'(v.exp_strobe & ~v.wr));
        if (v.exp_strobe) begin
            chk("offset", 32'(reg_addr_offset), 32'(v.addr[11:0]));
            chk("wdata", reg_wdata, v.wdata);
        end
        nstb = int'(reg_wr_en) + int'(reg_rd_en);
        lat  = 99;
        err  = 1'b0;
        rd   = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            reg_ack = (k == v.ack_dly);
            if (k == 1) begin
                paddr  = 32'h4000_1FF0;
                pwdata = ~v.wdata;
            end
            #1;
            if (k == 1 && v.exp_strobe && v.exp_lat > 1) begin
                chk("held_offset", 32'(reg_addr_offset), 32'(v.addr[11:0]));
                chk("held_wdata", reg_wdata, v.wdata);
            end
            nstb += int'(reg_wr_en) + int'(reg_rd_en);
            if (pready) begin
                lat = k;
                err = pslverr;
                rd  = prdata;
                break;
            end
        end
        chk("latency", lat, v.exp_lat);
        chk("pslverr", 32'(err), 32'(v.exp_err));
        chk("prdata", rd, v.exp_prdata);
        chk("strobe_count", nstb, 32'(v.exp_strobe));
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; reg_ack = 1'b0;
        #1 chk("pready_one_cycle", 32'(pready), 32'd0);
    endtask

    initial begin
        vec_t tv;
        //           addr           wr    wdata          ack  rdata          lat err   prdata         strobe
        vecs[0]  = '{32'h4000_1010, 1'b1, 32'hDEAD_BEEF,  0, 32'h0000_0000,  1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1]  = '{32'h4000_1004, 1'b0, 32'h0000_0000,  3, 32'h1234_5678,  4, 1'b0, 32'h1234_5678, 1'b1};
        vecs[2]  = '{32'h4000_2000, 1'b0, 32'h0000_0000, -1, 32'h0000_0000,  1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h4000_1002, 1'b0, 32'h0000_0000, -1, 32'h0000_0000,  1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[4]  = '{32'h4000_1100, 1'b0, 32'h0000_0000, -1, 32'h0000_0000,  1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{32'h4000_10FC, 1'b0, 32'h0000_0000,  0, 32'hA5A5_A5A5,  1, 1'b0, 32'hA5A5_A5A5, 1'b1};
        vecs[6]  = '{32'h4000_1020, 1'b1, 32'h0102_0304,  2, 32'hFFFF_FFFF,  3, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{32'h4000_1030, 1'b0, 32'h0000_0000, -1, 32'h5555_AAAA, 16, 1'b1, 32'h0000_0000, 1'b1};
        vecs[8]  = '{32'h4000_2010, 1'b1, 32'h7777_7777,  0, 32'h9999_9999,  1, 1'b1, 32'h0000_0000, 1'b0};
        vecs[9]  = '{32'h4000_1040, 1'b0, 32'h0000_0000, 15, 32'h0BAD_F00D, 16, 1'b0, 32'h0BAD_F00D, 1'b1};
        vecs[10] = '{32'h4000_1000, 1'b1, 32'h0000_0001,  1, 32'h0000_0000,  2, 1'b0, 32'h0000_0000, 1'b1};

        // Reset with a valid access pending: everything must stay quiet.
        rst_n = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h4000_1000; pwdata = 32'h1111_1111; reg_ack = 1'b1; reg_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; reg_ack = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_xfer(vecs[i]);
        end

        // Write timeout, then a stray ack at T+20 must be ignored.
        tv = '{32'h4000_1008, 1'b1, 32'hC0DE_0001, -1, 32'h0, 16, 1'b1, 32'h0, 1'b1};
        run_xfer(tv);
        repeat (3) @(negedge clk);
        reg_ack = 1'b1;
        #1;
        chk("late_ack_pready", 32'(pready), 32'd0);
        chk("late_ack_strobe", 32'(reg_wr_en | reg_rd_en), 32'd0);
        @(negedge clk);
        reg_ack = 1'b0;
        #1 chk("late_ack_after", 32'(pready), 32'd0);

        // psel dropped in WAIT aborts; a later ack produces nothing.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4000_1000;
        @(negedge clk);
        penable = 1'b1;
        #1 chk("abort_rd_en", 32'(reg_rd_en), 32'd1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1 chk("abort_pready", 32'(pready), 32'd0);
        @(negedge clk);
        reg_ack = 1'b1;
        #1 chk("abort_ack_pready", 32'(pready), 32'd0);
        @(negedge clk);
        reg_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("abort_idle_pready", 32'(pready), 32'd0);
        end

        // Reset asserted in WAIT, ack during reset, then release.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4000_1008; reg_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready), 32'd0);
        chk("midrst_pslverr", 32'(pslverr), 32'd0);
        chk("midrst_prdata", prdata, 32'd0);
        @(negedge clk);
        reg_ack = 1'b1;
        #1 chk("midrst_strobe", 32'(reg_wr_en | reg_rd_en), 32'd0);
        @(negedge clk);
        reg_ack = 1'b0; psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("postrst_pready", 32'(pready), 32'd0);
            @(negedge clk);
        end
        tv = '{32'h4000_1008, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D, 1'b1};
        run_xfer(tv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
